led_pwm_pio: RTL and testbench

//  Parametrised Avalon-MM slave output PIO driving WIDTH LED/GPIO lines; next generation of the 2-bit LED PIO.

---
 rtl/led_pio_pkg.sv | 13 +
 rtl/led_pwm_timebase.sv | 47 ++++
 rtl/led_pwm_pio.sv | 105 ++++++++++
 tb/tb_led_pwm_pio.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared register map for the LED/GPIO PWM PIO slave.
package led_pio_pkg;

    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET       = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_DIV = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 3'd5;

endpackage

// File: rtl/led_pwm_timebase.sv
// Blink prescaler / phase generator and free-running PWM comparator.
module led_pwm_timebase #(
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  blink_div,
    input  logic              div_load,
    input  logic [DUTY_W-1:0] duty,
    output logic              blink_phase,
    output logic              pwm_on_c
);

    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_blink_phase;
    logic [DUTY_W-1:0] r_pwm_cnt;

    // A BLINK_DIV write restarts the period with the phase high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_blink_phase <= 1'b1;
        end else if (div_load) begin
            r_div_cnt     <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_div_cnt == blink_div) begin
            r_div_cnt     <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_div_cnt     <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
        end
    end

    // All-ones duty must be fully on, which the plain compare cannot reach
    assign pwm_on_c    = (duty == '1) || (r_pwm_cnt < duty);
    assign blink_phase = r_blink_phase;

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM output PIO with atomic set/clear, per-bit blink and global PWM dimming.
module led_pwm_pio
    import led_pio_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIV_W   = 24,
    parameter int unsigned DUTY_W  = 8,
    parameter int unsigned DIV_RST = 2499999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  r_mode;
    logic [DIV_W-1:0]  r_blink_div;
    logic [DUTY_W-1:0] r_duty;
    logic [WIDTH-1:0]  r_out_port;

    logic              w_wr;
    logic              w_div_load;
    logic [WIDTH-1:0]  w_data_nxt;
    logic              w_blink_phase;
    logic              w_pwm_on;
    logic              w_unused;

    assign w_wr       = chipselect & ~write_n;
    assign w_div_load = w_wr && (address == ADDR_BLINK_DIV);
    assign w_unused   = &{1'b0, writedata};

    // DATA, SET and CLEAR all funnel into the one data_out register
    always_comb begin
        w_data_nxt = r_data;
        if (w_wr) begin
            case (address)
                ADDR_DATA:  w_data_nxt = writedata[WIDTH-1:0];
                ADDR_SET:   w_data_nxt = r_data | writedata[WIDTH-1:0];
                ADDR_CLEAR: w_data_nxt = r_data & ~writedata[WIDTH-1:0];
                default:    w_data_nxt = r_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= '0;
            r_mode      <= '0;
            r_blink_div <= DIV_W'(DIV_RST);
            r_duty      <= '1;
        end else begin
            r_data <= w_data_nxt;
            if (w_wr && (address == ADDR_MODE)) begin
                r_mode <= writedata[WIDTH-1:0];
            end
            if (w_div_load) begin
                r_blink_div <= writedata[DIV_W-1:0];
            end
            if (w_wr && (address == ADDR_DUTY)) begin
                r_duty <= writedata[DUTY_W-1:0];
            end
        end
    end

    led_pwm_timebase #(
        .DIV_W  (DIV_W),
        .DUTY_W (DUTY_W)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .blink_div   (r_blink_div),
        .div_load    (w_div_load),
        .duty        (r_duty),
        .blink_phase (w_blink_phase),
        .pwm_on_c    (w_pwm_on)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_port <= '0;
        end else begin
            r_out_port <= r_data & (~r_mode | {WIDTH{w_blink_phase}}) & {WIDTH{w_pwm_on}};
        end
    end

    assign out_port = r_out_port;

    // Zero-wait read; SET/CLEAR and unmapped words read as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'(r_data);
            ADDR_MODE:      readdata = 32'(r_mode);
            ADDR_BLINK_DIV: readdata = 32'(r_blink_div);
            ADDR_DUTY:      readdata = 32'(r_duty);
            default:        readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Directed self-checking bench for led_pwm_pio (WIDTH=8, DIV_W=24, DUTY_W=8).
module tb_led_pwm_pio;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DIV_W   = 24;
    localparam int unsigned DUTY_W  = 8;
    localparam int unsigned DIV_RST = 2499999;

    logic             clk;
    logic             reset;
    logic             chipselect;
    logic [2:0]       address;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int n_checks;
    int n_fail;

    led_pwm_pio #(
        .WIDTH   (WIDTH),
        .DIV_W   (DIV_W),
        .DUTY_W  (DUTY_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns just after the edge that performs the write
    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        address = addr;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        int n_on;
        int n_other;
        logic [7:0] exp_out;

        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;

        // 1: reset values
        step();
        step();
        reset = 1'b0;
        check("rst_out", 32'(out_port), 32'h0);
        rd_chk("rst_data", 3'd0, 32'h0);
        rd_chk("rst_mode", 3'd1, 32'h0);
        rd_chk("rst_div",  3'd4, 32'd2499999);
        rd_chk("rst_duty", 3'd5, 32'hFF);

        // 2: DATA / SET / CLEAR with latency
        wr(3'd0, 32'hA5);
        rd_chk("data_a5", 3'd0, 32'hA5);
        check("out_lat", 32'(out_port), 32'h0);
        step();
        check("out_a5", 32'(out_port), 32'hA5);
        wr(3'd2, 32'h0F);
        rd_chk("set_data", 3'd0, 32'hAF);
        rd_chk("set_rd0",  3'd2, 32'h0);
        step();
        check("out_af", 32'(out_port), 32'hAF);
        wr(3'd3, 32'hA0);
        rd_chk("clr_data", 3'd0, 32'h0F);
        rd_chk("clr_rd0",  3'd3, 32'h0);
        step();
        check("out_0f", 32'(out_port), 32'h0F);

        // 3: blink bit0 with period 4, bit1 static
        wr(3'd1, 32'h01);
        wr(3'd0, 32'h03);
        wr(3'd4, 32'd3);
        rd_chk("div_3", 3'd4, 32'd3);
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_out = (((k - 1) / 4) % 2 == 0) ? 8'h03 : 8'h02;
            check($sformatf("blink_%0d", k), 32'(out_port), 32'(exp_out));
        end

        // 4: PWM dimming
        wr(3'd1, 32'h00);
        wr(3'd0, 32'hFF);
        wr(3'd5, 32'h40);
        rd_chk("duty_40", 3'd5, 32'h40);
        n_on = 0;
        n_other = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port == 8'hFF) n_on++;
            else if (out_port != 8'h00) n_other++;
        end
        check("pwm40_on", 32'(n_on), 32'd64);
        check("pwm40_other", 32'(n_other), 32'd0);

        wr(3'd5, 32'h00);
        n_on = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port != 8'h00) n_on++;
        end
        check("pwm00_on", 32'(n_on), 32'd0);

        wr(3'd5, 32'hFF);
        n_on = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port == 8'hFF) n_on++;
        end
        check("pwmff_on", 32'(n_on), 32'd256);

        // 5: unmapped addresses, unselected write, wide writedata
        wr(3'd6, 32'hFFFFFFFF);
        wr(3'd7, 32'hFFFFFFFF);
        rd_chk("a6_rd",  3'd6, 32'h0);
        rd_chk("a7_rd",  3'd7, 32'h0);
        rd_chk("a67_data", 3'd0, 32'hFF);
        rd_chk("a67_mode", 3'd1, 32'h0);
        rd_chk("a67_div",  3'd4, 32'd3);
        rd_chk("a67_duty", 3'd5, 32'hFF);
        step();
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h12;
        step();
        write_n    = 1'b1;
        rd_chk("nocs_data", 3'd0, 32'hFF);
        wr(3'd0, 32'hFFFFFF5A);
        rd_chk("wide_data", 3'd0, 32'h5A);

        // 6: reset mid-blink with a same-cycle DATA write
        wr(3'd1, 32'hFF);
        wr(3'd4, 32'd1);
        step();
        step();
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h77;
        step();
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("rst2_out", 32'(out_port), 32'h0);
        rd_chk("rst2_data", 3'd0, 32'h0);
        rd_chk("rst2_mode", 3'd1, 32'h0);
        rd_chk("rst2_div",  3'd4, 32'd2499999);
        rd_chk("rst2_duty", 3'd5, 32'hFF);
        step();
        check("rst2_out_next", 32'(out_port), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
